// File: rtl/uart_time_loader.sv
// uart_time_loader: 8N1 UART receiver and parser for ASCII time/date set-commands
module uart_time_loader #(
  parameter int CLK_HZ   = 100_000_000,
  parameter int BAUD     = 115200,
  parameter int RST_YEAR = 2000
) (
  input  logic        clk_100MHz,
  input  logic        reset,
  input  logic        rx,
  output logic [16:0] time_out,
  output logic [20:0] date_out,
  output logic        overwrite,
  output logic        load_date,
  output logic        err
);
  localparam int BIT_DIV = CLK_HZ / BAUD;
  localparam int HALF    = BIT_DIV / 2;
  localparam int CW      = $clog2(BIT_DIV + 1);
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_t;
  typedef enum logic [2:0] {P_IDLE, P_DIG, P_CR, P_CHK, P_LOAD} p_t;
  rx_t rs;
  p_t st;
  logic rx_s1, rx_s2, rx_d, bv, ferr, is_date;
  logic [CW-1:0] cnt;
  logic [2:0] bitn;
  logic [7:0] sh;
  logic [3:0] need;
  logic [6:0] fa, fb;
  logic [13:0] fc;
  logic is_t, is_d, is_dig, ok;
  logic [1:0] sel;
  always_ff @(posedge clk_100MHz or negedge reset)
    if (!reset) begin
      rx_s1 <= 1'b1;
      rx_s2 <= 1'b1;
      rx_d  <= 1'b1;
      rs    <= RX_IDLE;
      cnt   <= '0;
      bitn  <= '0;
      sh    <= '0;
      bv    <= 1'b0;
      ferr  <= 1'b0;
    end else begin
      rx_s1 <= rx;
      rx_s2 <= rx_s1;
      rx_d  <= rx_s2;
      bv    <= 1'b0;
      ferr  <= 1'b0;
      case (rs)
        RX_IDLE: if (rx_d && !rx_s2) begin
          rs  <= RX_START;
          cnt <= '0;
        end
        RX_START: if (cnt == CW'(HALF - 1)) begin
          cnt  <= '0;
          bitn <= '0;
          rs   <= rx_s2 ? RX_IDLE : RX_DATA;
        end else cnt <= cnt + 1'b1;
        RX_DATA: if (cnt == CW'(BIT_DIV - 1)) begin
          cnt  <= '0;
          sh   <= {rx_s2, sh[7:1]};
          bitn <= bitn + 3'd1;
          if (bitn == 3'd7) rs <= RX_STOP;
        end else cnt <= cnt + 1'b1;
        default: if (cnt == CW'(BIT_DIV - 1)) begin
          cnt  <= '0;
          rs   <= RX_IDLE;
          bv   <= rx_s2;
          ferr <= !rx_s2;
        end else cnt <= cnt + 1'b1;
      endcase
    end
  assign is_t   = sh == 8'h54 || sh == 8'h74;
  assign is_d   = sh == 8'h44 || sh == 8'h64;
  assign is_dig = sh >= 8'h30 && sh <= 8'h39;
  // field under construction, chosen by how many digits remain
  assign sel = is_date ? (need > 4'd6 ? 2'd0 : need > 4'd4 ? 2'd1 : 2'd2)
                       : (need > 4'd4 ? 2'd0 : need > 4'd2 ? 2'd1 : 2'd2);
  assign ok = is_date ? (fa >= 7'd1 && fa <= 7'd31 && fb >= 7'd1 && fb <= 7'd12 && fc <= 14'd4095)
                      : (fa <= 7'd23 && fb <= 7'd59 && fc <= 14'd59);
  always_ff @(posedge clk_100MHz or negedge reset)
    if (!reset) begin
      st        <= P_IDLE;
      need      <= '0;
      is_date   <= 1'b0;
      fa        <= '0;
      fb        <= '0;
      fc        <= '0;
      time_out  <= '0;
      date_out  <= {12'(RST_YEAR), 4'd1, 5'd1};
      overwrite <= 1'b0;
      load_date <= 1'b0;
      err       <= 1'b0;
    end else begin
      overwrite <= 1'b0;
      err       <= 1'b0;
      if (ferr) begin
        st  <= P_IDLE;
        err <= 1'b1;
      end else if (bv && (is_t || is_d) && (st == P_IDLE || st == P_DIG)) begin
        st      <= P_DIG;
        is_date <= is_d;
        need    <= is_d ? 4'd8 : 4'd6;
        fa      <= '0;
        fb      <= '0;
        fc      <= '0;
      end else case (st)
        P_DIG: if (bv) begin
          if (is_dig) begin
            if (sel == 2'd0) fa <= fa * 7'd10 + {3'd0, sh[3:0]};
            if (sel == 2'd1) fb <= fb * 7'd10 + {3'd0, sh[3:0]};
            if (sel == 2'd2) fc <= fc * 14'd10 + {10'd0, sh[3:0]};
            need <= need - 4'd1;
            if (need == 4'd1) st <= P_CR;
          end else begin
            err <= 1'b1;
            st  <= P_IDLE;
          end
        end
        P_CR: if (bv) begin
          st  <= sh == 8'h0D ? P_CHK : P_IDLE;
          err <= sh != 8'h0D;
        end
        // results are registered here so they are visible during P_LOAD
        P_CHK: if (ok) begin
          st        <= P_LOAD;
          overwrite <= 1'b1;
          load_date <= is_date;
          if (is_date) date_out <= {fc[11:0], fb[3:0], fa[4:0]};
          else time_out <= {fa[4:0], fb[5:0], fc[5:0]};
        end else begin
          err <= 1'b1;
          st  <= P_IDLE;
        end
        default: st <= P_IDLE;
      endcase
    end
endmodule

// File: tb/tb_uart_time_loader.sv
// tb_uart_time_loader: directed and randomized UART commands against a byte-level command model
module tb_uart_time_loader;
  localparam int CLK_HZ = 1_000_000;
  localparam int BAUD   = 100_000;
  localparam int BD     = CLK_HZ / BAUD;
  localparam int RY     = 2000;
  logic clk = 1'b0, reset = 1'b0, rx = 1'b1;
  logic [16:0] time_out;
  logic [20:0] date_out;
  logic overwrite, load_date, err;
  uart_time_loader #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .RST_YEAR(RY)) dut (
    .clk_100MHz(clk), .reset(reset), .rx(rx), .time_out(time_out), .date_out(date_out),
    .overwrite(overwrite), .load_date(load_date), .err(err)
  );
  always #5 clk = ~clk;
  int n_cmp = 0, n_bad = 0, ow_cnt = 0, err_cnt = 0;
  logic prev_ow = 1'b0;
  int exp_ow = 0, exp_err = 0;
  logic [16:0] exp_time = '0;
  logic [20:0] exp_date = {12'(RY), 4'd1, 5'd1};
  logic exp_ld = 1'b0;
  bit active = 0, mdate = 0;
  int dg[$];
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  always @(negedge clk) begin
    if (overwrite) begin
      ow_cnt++;
      check("ow_err_excl", 32'(err), 32'd0);
      check("ow_one_cycle", 32'(prev_ow), 32'd0);
    end
    if (err) err_cnt++;
    prev_ow = overwrite;
  end
  function automatic bit is_cmd(input logic [7:0] b);
    return b == "T" || b == "t" || b == "D" || b == "d";
  endfunction
  task automatic start_cmd(input logic [7:0] b);
    active = 1;
    mdate = b == "D" || b == "d";
    dg.delete();
  endtask
  task automatic evaluate();
    if (mdate) begin
      int d = dg[0] * 10 + dg[1];
      int m = dg[2] * 10 + dg[3];
      int y = dg[4] * 1000 + dg[5] * 100 + dg[6] * 10 + dg[7];
      if (d >= 1 && d <= 31 && m >= 1 && m <= 12 && y <= 4095) begin
        exp_ow++;
        exp_date = {y[11:0], m[3:0], d[4:0]};
        exp_ld = 1'b1;
      end else exp_err++;
    end else begin
      int h = dg[0] * 10 + dg[1];
      int m = dg[2] * 10 + dg[3];
      int s = dg[4] * 10 + dg[5];
      if (h <= 23 && m <= 59 && s <= 59) begin
        exp_ow++;
        exp_time = {h[4:0], m[5:0], s[5:0]};
        exp_ld = 1'b0;
      end else exp_err++;
    end
  endtask
  task automatic model_byte(input logic [7:0] b, input logic stop);
    int need = mdate ? 8 : 6;
    if (!stop) begin
      exp_err++;
      active = 0;
    end else if (!active) begin
      if (is_cmd(b)) start_cmd(b);
    end else if (dg.size() == need) begin
      if (b == 8'h0D) evaluate();
      else exp_err++;
      active = 0;
    end else if (b >= 8'h30 && b <= 8'h39) dg.push_back(int'(b) - 48);
    else if (is_cmd(b)) start_cmd(b);
    else begin
      exp_err++;
      active = 0;
    end
  endtask
  task automatic send_byte(input logic [7:0] b, input logic stop);
    rx = 1'b0;
    repeat (BD) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (BD) @(negedge clk);
    end
    rx = stop;
    repeat (BD) @(negedge clk);
    rx = 1'b1;
    repeat (4) @(negedge clk);
    model_byte(b, stop);
  endtask
  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i], 1'b1);
  endtask
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    active = 0;
    exp_time = '0;
    exp_date = {12'(RY), 4'd1, 5'd1};
    exp_ld = 1'b0;
    repeat (2) @(negedge clk);
  endtask
  task automatic verify(input string tag);
    repeat (20) @(negedge clk);
    check({tag, ".ow"}, 32'(ow_cnt), 32'(exp_ow));
    check({tag, ".err"}, 32'(err_cnt), 32'(exp_err));
    check({tag, ".time"}, 32'(time_out), 32'(exp_time));
    check({tag, ".date"}, 32'(date_out), 32'(exp_date));
    check({tag, ".ld"}, 32'(load_date), 32'(exp_ld));
  endtask
  initial begin
    logic [7:0] q[$];
    repeat (3) @(negedge clk);
    check("rst_time_in", 32'(time_out), 32'd0);
    check("rst_date_in", 32'(date_out), 32'({12'd2000, 4'd1, 5'd1}));
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_ow", 32'(overwrite), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_ld", 32'(load_date), 32'd0);
    send_str("T235959\r");
    verify("t1");
    check("t1_time_lit", 32'(time_out), 32'({5'd23, 6'd59, 6'd59}));
    send_str("D29021999\r");
    verify("t2");
    check("t2_date_lit", 32'(date_out), 32'({12'd1999, 4'd2, 5'd29}));
    do_reset();
    send_str("T245900\r");
    send_str("D00011999\r");
    verify("t3");
    do_reset();
    send_str("T12a400\r");
    send_str("T1234\r");
    send_str("T12T083000\r");
    verify("t4");
    check("t4_time_lit", 32'(time_out), 32'({5'd8, 6'd30, 6'd0}));
    do_reset();
    send_str("T1");
    send_byte("2", 1'b0);
    rx = 1'b0;
    repeat (BD * 4 / 10) @(negedge clk);
    rx = 1'b1;
    repeat (3 * BD) @(negedge clk);
    send_str("T010203\r");
    verify("t5");
    do_reset();
    send_str("D0101");
    do_reset();
    verify("t6_mid");
    send_str("D01012023\r");
    verify("t6");
    for (int n = 0; n < 16; n++) begin
      bit dt = $urandom_range(0, 1) == 1;
      bit lc = $urandom_range(0, 1) == 1;
      int a = dt ? $urandom_range(0, 33) : $urandom_range(0, 26);
      int b = dt ? $urandom_range(0, 13) : $urandom_range(0, 62);
      int c = dt ? $urandom_range(0, 5000) : $urandom_range(0, 62);
      q.delete();
      if ($urandom_range(0, 3) == 0) q.push_back(8'h0A);
      q.push_back(dt ? (lc ? "d" : "D") : (lc ? "t" : "T"));
      q.push_back(8'(48 + a / 10));
      q.push_back(8'(48 + a % 10));
      q.push_back(8'(48 + b / 10));
      q.push_back(8'(48 + b % 10));
      if (dt) begin
        q.push_back(8'(48 + c / 1000));
        q.push_back(8'(48 + (c / 100) % 10));
      end
      q.push_back(8'(48 + (c / 10) % 10));
      q.push_back(8'(48 + c % 10));
      q.push_back(8'h0D);
      if ($urandom_range(0, 4) == 0) q[$urandom_range(1, q.size() - 1)] = 8'($urandom_range(32, 126));
      foreach (q[i]) send_byte(q[i], 1'b1);
      verify("rnd");
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
